multicycle_control: RTL

- Moore-style main-control FSM for the multi-cycle MIPS datapath: shared instruction/data memory, IR, A/B/ALUOut registers.
- Sequences each instruction over 3-5 states and drives every datapath enable and mux select.
- Stalls on a memory ready handshake and flags illegal opcodes and memory timeouts.
- ALU encoding matches the single-cycle core: AND=000, OR=001, ADD=010, NOR=011, SUB=110, SLT=111.

---
 rtl/multicycle_control_if.sv | 37 +++
 rtl/multicycle_control.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multi-cycle MIPS main-control FSM.
// master = control unit (drives enables and selects), slave = datapath side.
interface multicycle_control_if;
  logic [5:0] OP;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_ready;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ULASrcA;
  logic [1:0] ULASrcB;
  logic [2:0] ULAControl;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic       illegal_op;
  logic       bus_error;
  logic [3:0] state_o;

  modport master (
    input  OP, Funct, Zero, mem_ready,
    output IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ULASrcA, ULASrcB, ULAControl, PCSrc, PCEn, illegal_op, bus_error,
           state_o
  );

  modport slave (
    output OP, Funct, Zero, mem_ready,
    input  IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ULASrcA, ULASrcB, ULAControl, PCSrc, PCEn, illegal_op, bus_error,
           state_o
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore main-control FSM for the multi-cycle MIPS datapath, with memory-wait timeout.
// Optional bne support is enabled by defining MULTICYCLE_BNE_EN.
module multicycle_control #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_error_q, bus_error_d;

  logic       iord, mem_read, mem_write, ir_write, reg_dst, memto_reg, reg_write;
  logic       src_a, pc_write, branch, br_cond, illegal, mem_wait, timeout;
  logic [1:0] src_b, pc_src;
  logic [2:0] alu_ctl;
  logic [2:0] funct_alu;
  logic       funct_ok;

  always_comb begin
    funct_alu = ALU_ADD;
    funct_ok  = 1'b1;
    case (bus.Funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b100111: funct_alu = ALU_NOR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // Branch sense: beq takes on Zero; bne (when enabled) on ~Zero.
  always_comb begin
    br_cond = bus.Zero;
`ifdef MULTICYCLE_BNE_EN
    if (bus.OP == OP_BNE) br_cond = ~bus.Zero;
`endif
  end

  always_comb begin
    state_d   = state_q;
    iord      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_dst   = 1'b0;
    memto_reg = 1'b0;
    reg_write = 1'b0;
    src_a     = 1'b0;
    src_b     = 2'b00;
    alu_ctl   = 3'b000;
    pc_src    = 2'b00;
    pc_write  = 1'b0;
    branch    = 1'b0;
    illegal   = 1'b0;
    mem_wait  = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        src_b    = 2'b01;
        alu_ctl  = ALU_ADD;
        // PC+4 and IR load commit together, only once memory delivers.
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else begin
          mem_wait = 1'b1;
        end
      end
      S_DECODE: begin
        src_b   = 2'b11;
        alu_ctl = ALU_ADD;
        case (bus.OP)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MULTICYCLE_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        src_a   = 1'b1;
        src_b   = 2'b10;
        alu_ctl = ALU_ADD;
        state_d = (bus.OP == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
        else               mem_wait = 1'b1;
      end
      S_MEMWB: begin
        reg_write = 1'b1;
        memto_reg = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
        else               mem_wait = 1'b1;
      end
      S_EXEC: begin
        src_a   = 1'b1;
        alu_ctl = funct_alu;
        if (funct_ok) begin
          state_d = S_ALUWB;
        end else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        src_a   = 1'b1;
        alu_ctl = ALU_SUB;
        pc_src  = 2'b01;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        src_a   = 1'b1;
        src_b   = 2'b10;
        alu_ctl = ALU_ADD;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // The timeout cycle is the TIMEOUT_CYCLES-th consecutive stalled cycle.
    timeout = mem_wait && (cnt_q == CNT_LAST);
    if (timeout) state_d = S_HALT;
    bus_error_d = bus_error_q | timeout;

    if (state_d != state_q) cnt_d = '0;
    else if (mem_wait)      cnt_d = cnt_q + CNT_W'(1);
    else                    cnt_d = cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      cnt_q       <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign bus.IorD       = iord;
  assign bus.MemRead    = mem_read;
  assign bus.MemWrite   = mem_write;
  assign bus.IRWrite    = ir_write;
  assign bus.RegDst     = reg_dst;
  assign bus.MemtoReg   = memto_reg;
  assign bus.RegWrite   = reg_write;
  assign bus.ULASrcA    = src_a;
  assign bus.ULASrcB    = src_b;
  assign bus.ULAControl = alu_ctl;
  assign bus.PCSrc      = pc_src;
  assign bus.PCEn       = pc_write | (branch & br_cond);
  assign bus.illegal_op = illegal & rst_n;
  assign bus.bus_error  = bus_error_q;
  assign bus.state_o    = state_q;

endmodule
